// File: rtl/l1_wishbone_arbiter_pkg.sv
// Shared types for the L1 Wishbone arbiter: FSM states, Wishbone cycle-type codes
// and the per-port request bundle.
package l1_wishbone_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam int SIZE_W = 5;

  typedef struct packed {
    logic [31:0]       addr;
    logic [31:0]       data;
    logic              rnw;
    logic [3:0]        be;
    logic [SIZE_W-1:0] size;
  } req_t;

endpackage

// File: rtl/round_robin_select.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module round_robin_select #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  request,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  int unsigned p;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    p     = 0;
    for (int k = 0; k < N; k++) begin
      p = (int'(ptr) + k) % N;
      if (!valid && request[p]) begin
        valid    = 1'b1;
        grant[p] = 1'b1;
        idx      = IW'(p);
      end
    end
  end

endmodule

// File: rtl/l1_wishbone_arbiter.sv
// Round-robin arbiter sharing one Wishbone master between NUM_PORTS L1 requesters.
// Optional watchdog abort enabled by defining L1_WB_ARBITER_TIMEOUT_EN.
module l1_wishbone_arbiter #(
  parameter int NUM_PORTS       = 2,
  parameter int MAX_BURST_WORDS = 32,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_PORTS*32-1:0] req_addr,
  input  logic [NUM_PORTS*32-1:0] req_data,
  input  logic [NUM_PORTS-1:0]   req_rnw,
  input  logic [NUM_PORTS*4-1:0] req_be,
  input  logic [NUM_PORTS*5-1:0] req_size,
  input  logic [NUM_PORTS-1:0]   req_request,
  output logic [NUM_PORTS-1:0]   req_ack,
  output logic [31:0]            rd_data,
  output logic [NUM_PORTS-1:0]   rd_data_valid,
  output logic [NUM_PORTS-1:0]   bus_err,
  output logic [29:0]            wb_adr,
  output logic [31:0]            wb_dat_w,
  output logic [3:0]             wb_sel,
  output logic                   wb_cyc,
  output logic                   wb_stb,
  output logic                   wb_we,
  output logic [2:0]             wb_cti,
  output logic [1:0]             wb_bte,
  input  logic [31:0]            wb_dat_r,
  input  logic                   wb_ack,
  input  logic                   wb_err
);
  import l1_wishbone_arbiter_pkg::*;

  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [SIZE_W-1:0] LEN_MAX = SIZE_W'(MAX_BURST_WORDS - 1);

  state_t            state;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     sel;
  logic [SIZE_W-1:0] len;
  logic [SIZE_W-1:0] cnt;

  req_t              reqs [NUM_PORTS];
  req_t              cur;
  logic [SIZE_W-1:0] cur_len;
  logic [NUM_PORTS-1:0] rr_grant;
  logic [IW-1:0]     rr_idx;
  logic              rr_valid;
  logic [IW-1:0]     ptr_next;
  logic              tmo_hit;
  logic              abort;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      reqs[i].addr = req_addr[32*i +: 32];
      reqs[i].data = req_data[32*i +: 32];
      reqs[i].rnw  = req_rnw[i];
      reqs[i].be   = req_be[4*i +: 4];
      reqs[i].size = req_size[5*i +: 5];
    end
  end

  round_robin_select #(
    .N  (NUM_PORTS),
    .IW (IW)
  ) u_rr (
    .request (req_request),
    .ptr     (ptr),
    .grant   (rr_grant),
    .idx     (rr_idx),
    .valid   (rr_valid)
  );

  assign cur      = reqs[rr_idx];
  // Writes are always single beats; reads are capped at the largest supported burst.
  assign cur_len  = !cur.rnw ? '0 : ((cur.size > LEN_MAX) ? LEN_MAX : cur.size);
  assign ptr_next = (rr_idx == IW'(NUM_PORTS - 1)) ? '0 : rr_idx + IW'(1);
  assign abort    = wb_err || tmo_hit;
  assign wb_bte   = 2'b00;

`ifdef L1_WB_ARBITER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES >= 256) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TW-1:0] tmo_cnt;
  logic [1:0]    unused_bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (!wb_cyc || wb_ack || wb_err || tmo_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // The count starts at 0 in the first waiting cycle, so this is the TIMEOUT_CYCLES-th one.
  assign tmo_hit     = wb_cyc && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign unused_bits = cur.addr[1:0];
`else
  logic [2:0] unused_bits;
  assign tmo_hit     = 1'b0;
  assign unused_bits = {cur.addr[1:0], (TIMEOUT_CYCLES != 0)};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      sel           <= '0;
      len           <= '0;
      cnt           <= '0;
      req_ack       <= '0;
      rd_data       <= '0;
      rd_data_valid <= '0;
      bus_err       <= '0;
      wb_adr        <= '0;
      wb_dat_w      <= '0;
      wb_sel        <= '0;
      wb_cyc        <= 1'b0;
      wb_stb        <= 1'b0;
      wb_we         <= 1'b0;
      wb_cti        <= CTI_CLASSIC;
    end else begin
      req_ack       <= '0;
      rd_data_valid <= '0;
      bus_err       <= '0;
      case (state)
        IDLE: begin
          if (rr_valid) begin
            sel      <= rr_idx;
            ptr      <= ptr_next;
            req_ack  <= rr_grant;
            len      <= cur_len;
            cnt      <= '0;
            wb_adr   <= cur.addr[31:2];
            wb_dat_w <= cur.data;
            wb_cyc   <= 1'b1;
            wb_stb   <= 1'b1;
            if (cur.rnw) begin
              state  <= READ;
              wb_we  <= 1'b0;
              wb_sel <= 4'hF;
              wb_cti <= (cur_len == '0) ? CTI_CLASSIC : CTI_INCR;
            end else begin
              state  <= WRITE;
              wb_we  <= 1'b1;
              wb_sel <= cur.be;
              wb_cti <= CTI_CLASSIC;
            end
          end
        end
        WRITE: begin
          if (wb_ack || abort) begin
            bus_err[sel] <= abort;
            wb_cyc       <= 1'b0;
            wb_stb       <= 1'b0;
            wb_we        <= 1'b0;
            state        <= IDLE;
          end
        end
        READ: begin
          if (abort) begin
            bus_err[sel] <= 1'b1;
            wb_cyc       <= 1'b0;
            wb_stb       <= 1'b0;
            state        <= IDLE;
          end else if (wb_ack) begin
            rd_data            <= wb_dat_r;
            rd_data_valid[sel] <= 1'b1;
            if (cnt == len) begin
              wb_cyc <= 1'b0;
              wb_stb <= 1'b0;
              state  <= IDLE;
            end else begin
              cnt    <= cnt + SIZE_W'(1);
              wb_adr <= wb_adr + 30'd1;
              wb_cti <= (cnt + SIZE_W'(1) == len) ? CTI_EOB : CTI_INCR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
